// File: rtl/instr_exec_unit_pkg.sv
// Shared types for the instruction register / execution stage.
package instr_register_pkg;

    localparam int PKG_ADDR_W = 5;
    localparam int PKG_OP_W   = 32;
    localparam int PKG_RES_W  = 64;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [PKG_OP_W-1:0]  operand_t;
    typedef logic signed [PKG_RES_W-1:0] result_t;
    typedef logic        [PKG_ADDR_W-1:0] address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } exec_state_t;

endpackage

// File: rtl/instr_exec_unit_if.sv
// Control, instruction-register and result port bundle of instr_exec_unit.
// master = controller / register file / writeback side, slave = exec unit.
interface instr_exec_unit_if
    import instr_register_pkg::*;
#(
    parameter int ADDR_W = PKG_ADDR_W
) ();

    logic              start;
    logic [ADDR_W-1:0] start_ptr;
    logic [ADDR_W:0]   num_instr;
    logic [ADDR_W-1:0] read_pointer;
    instruction_t      instruction_word;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    opcode_t           out_opc;
    operand_t          out_op_a;
    operand_t          out_op_b;
    result_t           out_result;
    logic              out_err;
    logic              done;

    modport master (
        output start, start_ptr, num_instr, instruction_word, out_ready,
        input  read_pointer, busy, out_valid, out_addr, out_opc, out_op_a,
               out_op_b, out_result, out_err, done
    );

    modport slave (
        input  start, start_ptr, num_instr, instruction_word, out_ready,
        output read_pointer, busy, out_valid, out_addr, out_opc, out_op_a,
               out_op_b, out_result, out_err, done
    );

endinterface

// File: rtl/instr_exec_unit_alu.sv
// Combinational opcode evaluator: f(opc, a, b) -> {result, err}.
// Macro INSTR_EXEC_DIV_EN: when defined, DIV/MOD are built; otherwise no
// divider exists and opcodes 6/7 report an error like illegal opcodes.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OP_W  = PKG_OP_W,
    parameter int RES_W = PKG_RES_W
) (
    input  opcode_t                 opc_i,
    input  logic signed [OP_W-1:0]  a_i,
    input  logic signed [OP_W-1:0]  b_i,
    output logic signed [RES_W-1:0] result_o,
    output logic                    err_o
);

    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;

    // Work at full result width so ADD/SUB cannot overflow and MULT keeps
    // the whole signed product.
    assign a_ext = {{(RES_W-OP_W){a_i[OP_W-1]}}, a_i};
    assign b_ext = {{(RES_W-OP_W){b_i[OP_W-1]}}, b_i};

`ifdef INSTR_EXEC_DIV_EN
    logic                    b_zero;
    logic signed [RES_W-1:0] b_safe;

    // Keep the divider away from a zero divisor; the result is discarded then.
    assign b_zero = (b_i == '0);
    assign b_safe = b_zero ? {{(RES_W-1){1'b0}}, 1'b1} : b_ext;
`endif

    // Opcode decode; anything not handled below is an error with result 0.
    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (opc_i)
            ZERO:  result_o = '0;
            PASSA: result_o = a_ext;
            PASSB: result_o = b_ext;
            ADD:   result_o = a_ext + b_ext;
            SUB:   result_o = a_ext - b_ext;
            MULT:  result_o = a_ext * b_ext;
`ifdef INSTR_EXEC_DIV_EN
            // SV signed divide truncates toward zero; % follows the dividend.
            DIV: begin
                if (b_zero) err_o = 1'b1;
                else        result_o = a_ext / b_safe;
            end
            MOD: begin
                if (b_zero) err_o = 1'b1;
                else        result_o = a_ext % b_safe;
            end
`endif
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Execution stage: walks a run of instruction-register locations, evaluates
// each word and offers it on a valid/ready port, one at a time.
// Optional divider selected by macro INSTR_EXEC_DIV_EN (inside instr_alu).
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int ADDR_W = PKG_ADDR_W,
    parameter int OP_W   = PKG_OP_W,
    parameter int RES_W  = PKG_RES_W
) (
    input logic              clk,
    input logic              reset_n,
    instr_exec_unit_if.slave bus
);

    localparam logic [ADDR_W:0]   MAX_N = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   N_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    exec_state_t             state_q, state_d;
    logic [ADDR_W-1:0]       rp_q, rp_d;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic [ADDR_W:0]         num_q, num_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    instruction_t            iw_q, iw_d;
    result_t                 res_q, res_d;
    logic                    err_q, err_d;
    logic                    valid_q, valid_d;

    logic signed [RES_W-1:0] alu_res;
    logic                    alu_err;
    logic                    last;

    instr_alu #(
        .OP_W  (OP_W),
        .RES_W (RES_W)
    ) u_alu (
        .opc_i    (iw_q.opc),
        .a_i      (iw_q.op_a),
        .b_i      (iw_q.op_b),
        .result_o (alu_res),
        .err_o    (alu_err)
    );

    assign last = ({1'b0, idx_q} == (num_q - N_ONE));

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = (bus.num_instr == '0) ? DONE : FETCH;
            FETCH: state_d = EXEC;
            EXEC:  state_d = OUT;
            OUT:   if (bus.out_ready) state_d = last ? DONE : FETCH;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy outside IDLE, done only for the single DONE cycle.
    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
    end

    // Datapath next state; every register holds unless its state updates it,
    // which keeps the OUT presentation stable under backpressure.
    always_comb begin
        rp_d    = rp_q;
        idx_d   = idx_q;
        num_d   = num_q;
        addr_d  = addr_q;
        iw_d    = iw_q;
        res_d   = res_q;
        err_d   = err_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rp_d  = bus.start_ptr;
                    idx_d = '0;
                    num_d = (bus.num_instr > MAX_N) ? MAX_N : bus.num_instr;
                end
            end
            FETCH: begin
                iw_d   = bus.instruction_word;
                addr_d = rp_q;
            end
            EXEC: begin
                res_d   = alu_res;
                err_d   = alu_err;
                valid_d = 1'b1;
            end
            OUT: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    if (!last) begin
                        idx_d = idx_q + A_ONE;
                        rp_d  = rp_q + A_ONE;   // wraps at the top of the file
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any run back to all-zero outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rp_q    <= '0;
            idx_q   <= '0;
            num_q   <= '0;
            addr_q  <= '0;
            iw_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rp_q    <= rp_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            addr_q  <= addr_d;
            iw_q    <= iw_d;
            res_q   <= res_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign bus.read_pointer = rp_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_addr     = addr_q;
    assign bus.out_opc      = iw_q.opc;
    assign bus.out_op_a     = iw_q.op_a;
    assign bus.out_op_b     = iw_q.op_b;
    assign bus.out_result   = res_q;
    assign bus.out_err      = err_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Scoreboard bench for instr_exec_unit: expected results are queued when a
// run is set up and popped when the DUT hands a result over.
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    typedef struct {
        logic [4:0]   addr;
        instruction_t w;
        longint       res;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    instruction_t mem [32];
    exp_t         sb [$];
    exp_t         mon_e;
    int           n_cmp = 0;
    int           n_bad = 0;

    instr_exec_unit_if bus ();

    instr_exec_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Instruction register model: combinational read.
    assign bus.instruction_word = mem[bus.read_pointer];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Reference arithmetic on 64-bit integers.
    function automatic void model(input instruction_t w, output longint r, output logic e);
        longint a, b;
        a = longint'(w.op_a);
        b = longint'(w.op_b);
        r = 0;
        e = 1'b0;
        case (int'(w.opc))
            0: r = 0;
            1: r = a;
            2: r = b;
            3: r = a + b;
            4: r = a - b;
            5: r = a * b;
            6, 7: begin
`ifdef INSTR_EXEC_DIV_EN
                if (b == 0) e = 1'b1;
                else if (int'(w.opc) == 6) r = a / b;
                else r = a % b;
`else
                e = 1'b1;
`endif
            end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic push_lit(input logic [4:0] addr, input int opc, input int a, input int b,
                            input longint res, input logic err);
        exp_t e;
        mem[addr].opc  = opcode_t'(opc);
        mem[addr].op_a = a;
        mem[addr].op_b = b;
        e.addr = addr;
        e.w    = mem[addr];
        e.res  = res;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic push_model(input logic [4:0] addr, input int opc, input int a, input int b);
        longint r;
        logic   e;
        instruction_t w;
        w.opc  = opcode_t'(opc);
        w.op_a = a;
        w.op_b = b;
        model(w, r, e);
        push_lit(addr, opc, a, b, r, e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rp"},     bus.read_pointer, 0);
        chk({tag, "_busy"},   bus.busy, 0);
        chk({tag, "_valid"},  bus.out_valid, 0);
        chk({tag, "_done"},   bus.done, 0);
        chk({tag, "_addr"},   bus.out_addr, 0);
        chk({tag, "_opc"},    bus.out_opc, 0);
        chk({tag, "_op_a"},   bus.out_op_a, 0);
        chk({tag, "_op_b"},   bus.out_op_b, 0);
        chk({tag, "_result"}, bus.out_result, 0);
        chk({tag, "_err"},    bus.out_err, 0);
    endtask

    // Result monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("out_addr",   bus.out_addr,   mon_e.addr);
                chk("out_opc",    bus.out_opc,    mon_e.w.opc);
                chk("out_op_a",   bus.out_op_a,   mon_e.w.op_a);
                chk("out_op_b",   bus.out_op_b,   mon_e.w.op_b);
                chk("out_result", bus.out_result, mon_e.res);
                chk("out_err",    bus.out_err,    mon_e.err);
            end
        end
    end

    // One run: start, optional backpressure on the first result, optional
    // start pulse while busy, then done timing / busy release checks.
    task automatic run(input logic [4:0] sp, input logic [5:0] n, input int stall, input bit poke);
        int cyc, hs_cyc, first_v, n_done, n_hs, stall_left, exp_n;
        bit in_stall;
        exp_n      = (n > 6'd32) ? 32 : int'(n);
        cyc        = 0;
        hs_cyc     = -100;
        first_v    = -1;
        n_done     = 0;
        n_hs       = 0;
        stall_left = stall;
        in_stall   = 1'b0;
        bus.start_ptr = sp;
        bus.num_instr = n;
        bus.out_ready = (stall == 0);
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        while (n_done == 0 && cyc < 400) begin
            @(negedge clk);
            if (bus.done) begin
                n_done = 1;
                if (exp_n == 0) chk("done_cyc_empty", cyc, 0);
                else            chk("done_after_last_hs", cyc, hs_cyc + 1);
                chk("busy_with_done", bus.busy, 1);
            end
            if (bus.out_valid && first_v < 0) first_v = cyc;
            if (!bus.out_ready && stall_left > 0 && (bus.out_valid || in_stall)) begin
                in_stall = 1'b1;
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_busy", bus.busy, 1);
                if (sb.size() > 0) begin
                    chk("stall_result", bus.out_result, sb[0].res);
                    chk("stall_addr", bus.out_addr, sb[0].addr);
                    chk("stall_rp", bus.read_pointer, sb[0].addr);
                end
                stall_left--;
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_cyc = cyc;
                n_hs++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (stall_left == 0) bus.out_ready = 1'b1;
            if (poke) begin
                bus.start     = (cyc == 3);
                bus.start_ptr = 5'd20;
                bus.num_instr = 6'd1;
            end
        end
        bus.start = 1'b0;
        if (n_done == 0) chk("done_timeout", 0, 1);
        chk("first_valid_cyc", first_v, (exp_n == 0) ? -1 : 2);
        chk("handshakes", n_hs, exp_n);
        chk("sb_drained", sb.size(), 0);
        @(negedge clk);
        chk("busy_after_done", bus.busy, 0);
        chk("done_one_cycle", bus.done, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.start_ptr = '0;
        bus.num_instr = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic run, with a start pulse while busy that must be ignored.
        push_lit(5'd0, 3, 5, -7, -2, 1'b0);
        push_lit(5'd1, 5, -3, 4, -12, 1'b0);
        push_lit(5'd2, 4, 10, 20, -10, 1'b0);
        run(5'd0, 6'd3, 0, 1'b1);

        // Same program, first result held off for 5 cycles.
        push_lit(5'd0, 3, 5, -7, -2, 1'b0);
        push_lit(5'd1, 5, -3, 4, -12, 1'b0);
        push_lit(5'd2, 4, 10, 20, -10, 1'b0);
        run(5'd0, 6'd3, 5, 1'b0);

        // Division, errors and width corner cases.
`ifdef INSTR_EXEC_DIV_EN
        push_lit(5'd4, 6, -7, 2, -3, 1'b0);
        push_lit(5'd5, 7, -7, 2, -1, 1'b0);
`else
        push_lit(5'd4, 6, -7, 2, 0, 1'b1);
        push_lit(5'd5, 7, -7, 2, 0, 1'b1);
`endif
        push_lit(5'd6, 6, 9, 0, 0, 1'b1);
`ifdef INSTR_EXEC_DIV_EN
        push_lit(5'd7, 6, 9, 3, 3, 1'b0);
`else
        push_lit(5'd7, 6, 9, 3, 0, 1'b1);
`endif
        push_lit(5'd8, 7, 5, 0, 0, 1'b1);
        push_lit(5'd9, 12, 3, 4, 0, 1'b1);
        push_lit(5'd10, 5, int'(32'h8000_0000), int'(32'h8000_0000),
                 longint'(64'h4000_0000_0000_0000), 1'b0);
`ifdef INSTR_EXEC_DIV_EN
        push_lit(5'd11, 7, 7, -2, 1, 1'b0);
`else
        push_lit(5'd11, 7, 7, -2, 0, 1'b1);
`endif
        push_lit(5'd12, 1, -5, 9, -5, 1'b0);
        push_lit(5'd13, 2, -5, 9, 9, 1'b0);
        push_lit(5'd14, 0, 1, 2, 0, 1'b0);
        push_lit(5'd15, 3, int'(32'h7fff_ffff), int'(32'h7fff_ffff), longint'(64'd4294967294), 1'b0);
        push_lit(5'd16, 4, int'(32'h8000_0000), 1, longint'(-64'sd2147483649), 1'b0);
        run(5'd4, 6'd13, 0, 1'b0);

        // Address wrap 30, 31, 0, 1.
        for (int i = 0; i < 4; i++)
            push_model(5'(30 + i), int'($urandom_range(0, 7)), int'($urandom), int'($urandom));
        run(5'd30, 6'd4, 0, 1'b0);

        // Empty run: done without any result.
        run(5'd7, 6'd0, 0, 1'b0);

        // Oversized count clamps to a full 32-entry run.
        for (int i = 0; i < 32; i++)
            push_model(5'(i), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 20)) - 10);
        run(5'd0, 6'd40, 0, 1'b0);

        // Reset while a result is waiting in OUT.
        bus.out_ready = 1'b0;
        bus.start_ptr = 5'd5;
        bus.num_instr = 6'd2;
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int w = 0; w < 10 && !bus.out_valid; w++) @(negedge clk);
        chk("mid_valid_up", bus.out_valid, 1);
        #2 reset_n = 1'b0;
        #1 chk_zero("midrun_reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_reset", bus.done, 0);
            chk("idle_after_reset", bus.busy, 0);
        end

        // Unit recovers normally after the abort.
        push_lit(5'd3, 1, 77, 0, 77, 1'b0);
        run(5'd3, 6'd1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
